// File: rtl/subtractor_serial.sv
// subtractor_serial: bit-serial subtractor D = A - B, LSB first, one bit per clock.
// The IDLE -> RUN -> DONE controller sits between a valid/ready operand port
// and a valid/ready result port. The operands are latched once. N cycles later
// the difference and the final borrow are presented and held until the consumer
// accepts them.
// Optional feature: define SUB_OVF_EN to add the registered signed-overflow
// output ovf. With the macro undefined the port and its logic are absent.
module subtractor_serial #(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] D,
    output logic         bout
`ifdef SUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  a_sh;
    logic [N-1:0]  b_sh;
    logic          borrow;
    logic [CW-1:0] count;

    // Full-subtractor cell for the operand bits at the bottom of the shifters.
    logic bit_a;
    logic bit_b;
    logic diff_bit;
    logic borrow_nxt;

    // One full-subtractor bit slice on the current LSBs and the running borrow.
    always_comb begin
        bit_a      = a_sh[0];
        bit_b      = b_sh[0];
        diff_bit   = bit_a ^ bit_b ^ borrow;
        borrow_nxt = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow);
    end

`ifdef SUB_OVF_EN
    // On the last bit the operand shifters hold the latched sign bits at [0].
    // diff_bit is the result sign. Overflow means the operand signs differ and
    // the result sign differs from the minuend sign.
    logic ovf_nxt;
    always_comb begin
        ovf_nxt = (bit_a != bit_b) && (diff_bit != bit_a);
    end
`endif

    // Controller and datapath: a single registered FSM. in_ready and out_valid
    // are state flags kept in flops, so neither output has a combinational path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            D         <= '0;
            bout      <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            borrow    <= 1'b0;
            count     <= '0;
`ifdef SUB_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // in_ready is 1 throughout IDLE, so in_valid alone is the handshake.
                    if (in_valid) begin
                        a_sh     <= A;
                        b_sh     <= B;
                        borrow   <= 1'b0;
                        count    <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end

                RUN: begin
                    // The result fills from the MSB end. After N shifts bit 0 is the LSB.
                    D      <= {diff_bit, D[N-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    borrow <= borrow_nxt;
                    if (count == LAST) begin
                        // The counter holds at N-1. It is reloaded on the next accept.
                        bout      <= borrow_nxt;
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef SUB_OVF_EN
                        ovf       <= ovf_nxt;
`endif
                    end else begin
                        count <= count + 1'b1;
                    end
                end

                DONE: begin
                    // Results stay frozen until the consumer takes them.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_subtractor_serial.sv
// Directed and randomised checks for subtractor_serial with N = 6.
// The ovf checks are compiled only when SUB_OVF_EN is defined.
module tb_subtractor_serial;

    localparam int N = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] D;
    logic         bout;
`ifdef SUB_OVF_EN
    logic         ovf;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    subtractor_serial #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .bout      (bout)
`ifdef SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents the operands and holds them until the accepting edge. Exits
    // one time unit after that edge.
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        A        = a;
        B        = b;
        for (int i = 0; i < 50 && !done; i++) begin
            if (in_ready) done = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    // Counts the clock edges from the accept until out_valid rises.
    task automatic wait_result(output int lat, input bit rnd_rdy);
        lat = 0;
        while (!out_valid && lat < 50) begin
            if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
            tick();
            lat++;
        end
        out_ready = 1'b0;
        if (!out_valid) chk("result_timeout", 32'd0, 32'd1);
    endtask

    task automatic take();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_hs_out_valid", 32'(out_valid), 32'd0);
        chk("post_hs_in_ready", 32'(in_ready), 32'd1);
    endtask

    // Runs one directed vector and checks the latency, D and bout.
    task automatic vec(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] exp_d, input logic exp_b);
        int lat;
        send(a, b);
        wait_result(lat, 1'b0);
        chk({tag, "_lat"}, 32'(lat), 32'd6);
        chk({tag, "_D"}, 32'(D), 32'(exp_d));
        chk({tag, "_bout"}, 32'(bout), 32'(exp_b));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [N-1:0] ra, rb, ed, d0;
        logic eb, b0;
        bit r;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        A = '0;
        B = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_D", 32'(D), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
`ifdef SUB_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif

        // Basic vector. Also checks that in_ready drops right after the accept.
        send(6'd5, 6'd3);
        chk("acc_in_ready", 32'(in_ready), 32'd0);
        wait_result(lat, 1'b0);
        chk("a5b3_lat", 32'(lat), 32'd6);
        chk("a5b3_D", 32'(D), 32'd2);
        chk("a5b3_bout", 32'(bout), 32'd0);
        take();

        vec("a3b5", 6'd3, 6'd5, 6'h3E, 1'b1);
        take();
        vec("a0b0", 6'd0, 6'd0, 6'd0, 1'b0);
        take();
        vec("a63b63", 6'd63, 6'd63, 6'd0, 1'b0);
        take();
        vec("a0b1", 6'd0, 6'd1, 6'h3F, 1'b1);
        take();
        vec("a32b1", 6'd32, 6'd1, 6'd31, 1'b0);
`ifdef SUB_OVF_EN
        chk("a32b1_ovf", 32'(ovf), 32'd1);
`endif
        take();
        vec("a31b1", 6'd31, 6'd1, 6'd30, 1'b0);
`ifdef SUB_OVF_EN
        chk("a31b1_ovf", 32'(ovf), 32'd0);
`endif
        take();

        // Stall in DONE while in_valid pulses with other operands.
        vec("stall", 6'd12, 6'd7, 6'd5, 1'b0);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            A = 6'd1;
            B = 6'd2;
            tick();
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_D", 32'(D), 32'd5);
            chk("stall_bout", 32'(bout), 32'd0);
        end
        in_valid = 1'b0;
        take();
        tick();
        chk("stall_single_hs", 32'(out_valid), 32'd0);

        // Reset while bit 3 of RUN is being processed.
        send(6'd7, 6'd2);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_D", 32'(D), 32'd0);
        vec("a9b4", 6'd9, 6'd4, 6'd5, 1'b0);
        take();

        // Random pairs with random out_ready, compared against an arithmetic model.
        for (int k = 0; k < 1000; k++) begin
            ra = 6'($urandom_range(0, 63));
            rb = 6'($urandom_range(0, 63));
            ed = ra - rb;
            eb = (ra < rb);
            send(ra, rb);
            wait_result(lat, 1'b1);
            chk("rnd_D", 32'(D), 32'(ed));
            chk("rnd_bout", 32'(bout), 32'(eb));
`ifdef SUB_OVF_EN
            chk("rnd_ovf", 32'(ovf), 32'((ra[N-1] != rb[N-1]) && (ed[N-1] != ra[N-1])));
`endif
            d0 = D;
            b0 = bout;
            r  = 1'b0;
            for (int j = 0; j < 50 && !r; j++) begin
                r = 1'($urandom_range(0, 1));
                out_ready = r;
                tick();
                if (!r) begin
                    chk("rnd_hold_D", 32'(D), 32'(d0));
                    chk("rnd_hold_bout", 32'(bout), 32'(b0));
                end
            end
            out_ready = 1'b0;
            chk("rnd_hs", 32'(out_valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
